// File: rtl/spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_target
//  Purpose  : SPI mode-0 target that bridges host transactions onto a simple
//             single-cycle register bus. The first byte of a transaction is a
//             command: bit7 = 1 for read, 0 for write, and bits6:0 = start
//             address. Each following byte is one register write or read.
//  Ports    : clk, reset_n                - system clock, async active-low reset
//             spi_sclk, spi_cs_n, spi_mosi - SPI inputs (asynchronous to clk)
//             spi_miso, spi_miso_oe        - SPI output data and output enable
//             addr, wdata, we, re          - register bus request side
//             rdata                        - register read data, valid one cycle
//                                            after re
//             busy                         - transaction in progress
//  Config   : `define SPI_TARGET_AUTOINC_EN selects burst mode, where addr
//             advances after every data byte. When it is undefined, addr stays
//             at the command address (FIFO-port mode).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_target (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [6:0] addr,
    output logic [7:0] wdata,
    output logic       we,
    output logic       re,
    input  logic [7:0] rdata,
    output logic       busy
);

`ifdef SPI_TARGET_AUTOINC_EN
    localparam bit c_autoinc = 1'b1;
`else
    localparam bit c_autoinc = 1'b0;
`endif

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    // Synchronizers, plus one extra stage per line for edge detection
    logic       r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic       r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic       r_mosi_meta, r_mosi_sync;
    // Marks when r_cs_sync holds a real sample instead of its reset value
    logic [1:0] r_sync_fill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_sync_fill <= 2'b00;
        end else begin
            r_sclk_meta <= spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
        end
    end

    logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [7:0] w_rx_next;

    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic       r_is_read;
    logic       r_armed;
    logic       r_re_d;
    logic       r_miso;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_re;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_rx_next   = {r_rx_sr, r_mosi_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 3'd0;
            r_rx_sr   <= 7'd0;
            r_tx_sr   <= 8'd0;
            r_is_read <= 1'b0;
            r_armed   <= 1'b0;
            r_re_d    <= 1'b0;
            r_miso    <= 1'b0;
            r_addr    <= 7'd0;
            r_wdata   <= 8'd0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_re_d <= r_re;

            // Once reset is released in the middle of a transaction, wait until
            // chip select is seen high before a transaction is allowed to start.
            if (r_sync_fill[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end

            // MISO shifts only during the data phase of a read. At all other
            // times it is held at 0.
            if (r_state == c_DATA && r_is_read) begin
                if (w_sclk_fall) begin
                    r_miso  <= r_tx_sr[7];
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                end
            end else begin
                r_miso <= 1'b0;
            end

            // Read data arrives one cycle after re. Loading it takes priority
            // over a shift in the same cycle.
            if (r_re_d) begin
                r_tx_sr <= rdata;
            end

            // A write advances the address one cycle after its strobe, so that
            // we is seen together with the address it targets.
            if (r_we && c_autoinc) begin
                r_addr <= r_addr + 7'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_cs_fall && r_armed) begin
                        r_state   <= c_CMD;
                        r_bit_cnt <= 3'd0;
                    end
                end
                c_CMD, c_DATA: begin
                    if (w_sclk_rise) begin
                        r_rx_sr   <= w_rx_next[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == c_CMD) begin
                                r_addr    <= w_rx_next[6:0];
                                r_is_read <= w_rx_next[7];
                                r_re      <= w_rx_next[7];
                                r_state   <= c_DATA;
                            end else if (r_is_read) begin
                                // Prefetch the byte that the next 8 clocks will shift out
                                r_re <= 1'b1;
                                if (c_autoinc) begin
                                    r_addr <= r_addr + 7'd1;
                                end
                            end else begin
                                r_wdata <= w_rx_next;
                                r_we    <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            // When chip select deasserts, the FSM always returns to IDLE. A byte
            // that completes in the same cycle has already taken its action above.
            if (w_cs_rise) begin
                r_state <= c_IDLE;
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = ~r_cs_sync;
    assign addr        = r_addr;
    assign wdata       = r_wdata;
    assign we          = r_we;
    assign re          = r_re;
    assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target
//  Purpose  : Directed testbench for spi_target. It contains an SPI host model
//             driving SCLK at clk/8 and a register-bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

`ifdef SPI_TARGET_AUTOINC_EN
    localparam bit c_autoinc = 1'b1;
`else
    localparam bit c_autoinc = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic [7:0] rdata = 8'h00;
    logic       busy;

    spi_target u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .re          (re),
        .rdata       (rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register-bus responder: read data is valid one cycle after re
    logic [7:0] mem [0:127];
    always @(posedge clk) begin
        if (re) rdata <= mem[addr];
        else    rdata <= 8'h00;
    end

    // Strobe log, sampled on the falling clk edge
    int         we_cnt = 0;
    int         re_cnt = 0;
    logic [6:0] we_addr [0:63];
    logic [7:0] we_data [0:63];
    logic [6:0] re_addr [0:63];
    always @(negedge clk) begin
        if (reset_n && we) begin
            if (we_cnt < 64) begin
                we_addr[we_cnt] = addr;
                we_data[we_cnt] = wdata;
            end
            we_cnt++;
        end
        if (reset_n && re) begin
            if (re_cnt < 64) re_addr[re_cnt] = addr;
            re_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts the top n bits of tx out MSB first and samples MISO before each rising edge
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            clk_wait(4);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            clk_wait(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_end();
        clk_wait(4);
        spi_cs_n = 1'b1;
        clk_wait(8);
    endtask

    logic [7:0] rx0, rx1, rx2, rx3;
    int         w0, r0;
    logic [6:0] exp_a;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h3C;
        mem[7'h11] = 8'hA7;

        // Reset state
        clk_wait(3);
        check("rst_miso",  spi_miso,    0);
        check("rst_oe",    spi_miso_oe, 0);
        check("rst_addr",  addr,        0);
        check("rst_wdata", wdata,       0);
        check("rst_we",    we,          0);
        check("rst_re",    re,          0);
        check("rst_busy",  busy,        0);
        reset_n = 1'b1;
        clk_wait(4);

        // Single write: command 0x05 followed by data 0xA5
        w0 = we_cnt; r0 = re_cnt;
        cs_start();
        spi_bits(8'h05, 8, rx0);
        check("wr_busy", busy, 1);
        check("wr_oe",   spi_miso_oe, 1);
        spi_bits(8'hA5, 8, rx1);
        cs_end();
        check("wr_we_cnt", we_cnt - w0, 1);
        check("wr_addr",   we_addr[w0], 7'h05);
        check("wr_data",   we_data[w0], 8'hA5);
        check("wr_re_cnt", re_cnt - r0, 0);
        check("wr_miso",   {rx0, rx1}, 16'h0000);
        check("wr_idle",   busy, 0);

        // Read: command 0x90, then 8 more bits return mem[0x10]
        w0 = we_cnt; r0 = re_cnt;
        cs_start();
        spi_bits(8'h90, 8, rx0);
        check("rd_re_cnt1", re_cnt - r0, 1);
        check("rd_re_addr", re_addr[r0], 7'h10);
        spi_bits(8'h00, 8, rx1);
        cs_end();
        check("rd_cmd_miso", rx0, 8'h00);
        check("rd_data",     rx1, 8'h3C);
        check("rd_re_cnt2",  re_cnt - r0, 2);
        exp_a = c_autoinc ? 7'h11 : 7'h10;
        check("rd_pf_addr",  re_addr[r0+1], exp_a);
        check("rd_we_cnt",   we_cnt - w0, 0);

        // Write burst starting at 0x7E: the address wraps to 0x00 in burst mode
        w0 = we_cnt;
        cs_start();
        spi_bits(8'h7E, 8, rx0);
        spi_bits(8'h11, 8, rx1);
        spi_bits(8'h22, 8, rx2);
        spi_bits(8'h33, 8, rx3);
        cs_end();
        check("bw_we_cnt", we_cnt - w0, 3);
        check("bw_addr0", we_addr[w0],   7'h7E);
        check("bw_addr1", we_addr[w0+1], c_autoinc ? 7'h7F : 7'h7E);
        check("bw_addr2", we_addr[w0+2], c_autoinc ? 7'h00 : 7'h7E);
        check("bw_data0", we_data[w0],   8'h11);
        check("bw_data1", we_data[w0+1], 8'h22);
        check("bw_data2", we_data[w0+2], 8'h33);

        // Partial byte aborted by CS rising
        w0 = we_cnt;
        cs_start();
        spi_bits(8'h01, 8, rx0);
        spi_bits(8'hFF, 5, rx1);
        spi_cs_n = 1'b1;
        clk_wait(8);
        check("ab_we_cnt", we_cnt - w0, 0);
        check("ab_busy",   busy, 0);
        w0 = we_cnt;
        cs_start();
        spi_bits(8'h02, 8, rx0);
        spi_bits(8'h99, 8, rx1);
        cs_end();
        check("ab_next_cnt",  we_cnt - w0, 1);
        check("ab_next_addr", we_addr[w0], 7'h02);
        check("ab_next_data", we_data[w0], 8'h99);

        // Reset asserted during byte 2 and released while CS is still low
        cs_start();
        spi_bits(8'h03, 8, rx0);
        spi_bits(8'hC3, 3, rx1);
        reset_n = 1'b0;
        clk_wait(3);
        check("mr_rst_busy", busy, 0);
        check("mr_rst_oe",   spi_miso_oe, 0);
        reset_n = 1'b1;
        w0 = we_cnt; r0 = re_cnt;
        spi_bits(8'h18, 5, rx1);
        spi_bits(8'h81, 8, rx2);
        spi_bits(8'h55, 8, rx3);
        check("mr_busy",    busy, 0);
        check("mr_strobes", (we_cnt - w0) + (re_cnt - r0), 0);
        cs_end();
        check("mr_strobes2", (we_cnt - w0) + (re_cnt - r0), 0);
        w0 = we_cnt;
        cs_start();
        spi_bits(8'h04, 8, rx0);
        spi_bits(8'h77, 8, rx1);
        cs_end();
        check("mr_next_cnt",  we_cnt - w0, 1);
        check("mr_next_addr", we_addr[w0], 7'h04);
        check("mr_next_data", we_data[w0], 8'h77);

        // SCLK toggling while CS stays high
        w0 = we_cnt; r0 = re_cnt;
        spi_bits(8'h85, 8, rx0);
        check("cs_hi_oe",   spi_miso_oe, 0);
        check("cs_hi_busy", busy, 0);
        spi_bits(8'h2A, 8, rx1);
        clk_wait(4);
        check("cs_hi_strobes", (we_cnt - w0) + (re_cnt - r0), 0);
        check("cs_hi_busy2",   busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: system clock; all logic is in this domain.
REQ-002 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port `spi_sclk`, input, 1 bit: SPI clock from the external host, asynchronous, mode 0, max frequency clk/8.
REQ-004 The block SHALL have port `spi_cs_n`, input, 1 bit: active-low chip select, asynchronous.
REQ-005 The block SHALL have port `spi_mosi`, input, 1 bit: host-to-target data, MSB first.
REQ-006 The block SHALL have port `spi_miso`, output, 1 bit: target-to-host data, MSB first.
REQ-007 The block SHALL have port `spi_miso_oe`, output, 1 bit: MISO output enable, high only while selected.
REQ-008 The block SHALL have port `addr`, output, 7 bits: register bus address.
REQ-009 The block SHALL have port `wdata`, output, 8 bits: register bus write data.
REQ-010 The block SHALL have port `we`, output, 1 bit: single-cycle write strobe.
REQ-011 The block SHALL have port `re`, output, 1 bit: single-cycle read strobe.
REQ-012 The block SHALL have port `rdata`, input, 8 bits: read data, valid exactly one clk cycle after `re`.
REQ-013 The block SHALL have port `busy`, output, 1 bit: high while a transaction is active.

Function
REQ-014 `spi_sclk`, `spi_cs_n` and `spi_mosi` SHALL pass through 2-flop synchronizers; SCLK edges SHALL be detected from the synchronized samples.
REQ-015 The FSM SHALL have states IDLE, CMD and DATA.
REQ-016 The FSM SHALL go IDLE->CMD on synchronized `spi_cs_n` falling, and SHALL clear the bit counter.
REQ-017 MOSI SHALL be sampled on SCLK rising edges; MISO SHALL update on SCLK falling edges.
REQ-018 The first byte SHALL be the command byte: bit7 = 1 for read, 0 for write; bits6:0 = start address.
REQ-019 On the 8th rising edge of the command byte, `addr` SHALL load the address and the FSM SHALL go CMD->DATA.
REQ-020 On that same 8th rising edge, if the command is a read, `re` SHALL pulse within 2 clk cycles.
REQ-021 In a write, each completed data byte SHALL drive `wdata` and pulse `we` for 1 cycle within 3 clk of the 8th rising edge; `addr` SHALL then advance.
REQ-022 In a read, `rdata` SHALL be captured into the TX shift register on the cycle after `re`.
REQ-023 In a read, the MSB SHALL be driven at the following falling edge; each completed data byte SHALL advance `addr` and pulse `re` to prefetch the next byte.
REQ-024 Address arithmetic SHALL be 7-bit modulo: 0x7F+1 -> 0x00.
REQ-025 `spi_miso` SHALL be 0 during the command byte and during write transactions.
REQ-026 `spi_miso_oe` SHALL equal the inverse of synchronized `spi_cs_n` whenever not in reset.
REQ-027 On CS rising, any state SHALL go to IDLE; a partial byte SHALL be discarded with no `we`, and an already-issued `re` is harmless.
REQ-028 `busy` SHALL be high in CMD and DATA.
REQ-029 A CS rise and a byte completion in the same cycle SHALL give the byte-completion action precedence; the FSM SHALL then go to IDLE.

Reset
REQ-030 While `reset_n` is low, outputs SHALL be: `spi_miso` 0, `spi_miso_oe` 0, `addr` 0, `wdata` 0, `we` 0, `re` 0, `busy` 0; the FSM SHALL be in IDLE; synchronizers SHALL hold the idle values CS=1, SCLK=0.
REQ-031 A reset released mid-transaction SHALL cause the block to ignore bus activity until synchronized `spi_cs_n` is seen high, then operate normally.

Configuration
REQ-032 Macro `SPI_TARGET_AUTOINC_EN` defined: `addr` SHALL increment after every data byte (burst mode).
REQ-033 Macro `SPI_TARGET_AUTOINC_EN` undefined: `addr` SHALL stay at the command address for the whole transaction (FIFO-port mode), and `re`/`we` SHALL still pulse per byte.

Verification
REQ-034 Write 0x05 then 0xA5 at SCLK = clk/8: exactly one `we` occurs, with `addr`=0x05 and `wdata`=0xA5; `re` never asserts.
REQ-035 Read 0x90 with `rdata`=0x3C, then clock 8 more bits: MISO returns 0x3C; one `re` occurs with `addr`=0x10 before byte 2, and a prefetch `re` occurs with `addr`=0x11 (AUTOINC_EN).
REQ-036 Write burst 0x7E with data 0x11, 0x22, 0x33: `we` occurs at addrs 0x7E, 0x7F, 0x00 (wrap); without the macro, all three `we` go to 0x7E.
REQ-037 Command 0x01 then 5 data bits, then CS rises: no `we` occurs, FSM is IDLE, `busy`=0; the next full transaction works normally.
REQ-038 Assert `reset_n` low during byte 2, release it while CS is still low, and keep clocking: no strobes occur until CS goes high; the following transaction works.
REQ-039 Hold CS high with SCLK toggling: no strobes occur, `spi_miso_oe`=0, `busy`=0.
